// File: rtl/ifu_bhtbpu_pkg.sv
// Shared constants, JALR-xn state encoding and the saturating counter step
// used by the IFU branch predictor.
package ifu_bhtbpu_pkg;

   localparam int DEF_PC_SIZE     = 32;
   localparam int DEF_XLEN        = 32;
   localparam int DEF_RFIDX_WIDTH = 5;

   localparam logic [1:0] BHT_CNT_RST = 2'b01;

   typedef enum logic [1:0] {
      JALR_IDLE = 2'd0,
      JALR_DEPW = 2'd1,
      JALR_RDRF = 2'd2,
      JALR_DONE = 2'd3
   } jalrState_e;

   function automatic logic [1:0] satCount(input logic [1:0] cnt, input logic up);
      logic [1:0] res;
      res = cnt;
      if (up && cnt != 2'b11) begin
         res = cnt + 2'b01;
      end else if (!up && cnt != 2'b00) begin
         res = cnt - 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/ifu_bht.sv
// Branch history table: one 2-bit saturating counter per entry, combinational
// lookup and a single trained entry per cycle.
module ifu_bht
   import ifu_bhtbpu_pkg::*;
#(
   parameter int BHT_DEPTH = 64,
   parameter int BHT_IDX_W = $clog2(BHT_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BHT_IDX_W-1:0] lkpIdx_i,
   output logic [1:0]           lkpCnt_o,
   input  logic                 updValid_i,
   input  logic [BHT_IDX_W-1:0] updIdx_i,
   input  logic                 updTaken_i
);

   logic [1:0] cnt_q [BHT_DEPTH];

   // Lookup reads the stored value, so a same-cycle update is not visible yet.
   assign lkpCnt_o = cnt_q[lkpIdx_i];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            cnt_q[i] <= BHT_CNT_RST;
         end
      end else if (updValid_i) begin
         cnt_q[updIdx_i] <= satCount(cnt_q[updIdx_i], updTaken_i);
      end
   end

endmodule

// File: rtl/ifu_bhtbpu.sv
// IFU branch predictor: BHT-based direction for conditional branches, target
// adder operands, and the JALR rs1 dependency / register-file read sequencing.
module ifu_bhtbpu
   import ifu_bhtbpu_pkg::*;
#(
   parameter int PC_SIZE     = DEF_PC_SIZE,
   parameter int XLEN        = DEF_XLEN,
   parameter int RFIDX_WIDTH = DEF_RFIDX_WIDTH,
   parameter int BHT_DEPTH   = 64,
   parameter int BHT_IDX_W   = $clog2(BHT_DEPTH),
   parameter bit BHT_EN      = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PC_SIZE-1:0]     pc,
   input  logic                   dec_i_valid,
   input  logic                   dec_jal,
   input  logic                   dec_jalr,
   input  logic                   dec_bxx,
   input  logic [XLEN-1:0]        dec_bjp_imm,
   input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
   input  logic                   oitf_x1_dep,
   input  logic                   oitf_rs1_dep,
   input  logic                   ir_valid_clr,
   input  logic [XLEN-1:0]        rf2bpu_x1,
   input  logic [XLEN-1:0]        rf2bpu_rs1,
   input  logic                   upd_valid,
   input  logic [PC_SIZE-1:0]     upd_pc,
   input  logic                   upd_taken,
   output logic                   bpu_wait,
   output logic                   prdt_taken,
   output logic [PC_SIZE-1:0]     prdt_pc_add_op1,
   output logic [PC_SIZE-1:0]     prdt_pc_add_op2,
   output logic                   bpu2rf_rs1_ena
);

   jalrState_e       state_q, state_d;
   logic [XLEN-1:0]  rs1_q, rs1_d;
   logic [1:0]       lkpCnt;
   logic             dirTaken;
   logic             rs1x0, rs1x1, rs1xn;
   logic             jalrXnReq, x1Wait, xnWait, rs1Ena;
   logic             unused_bits;

   ifu_bht #(
      .BHT_DEPTH (BHT_DEPTH),
      .BHT_IDX_W (BHT_IDX_W)
   ) u_bht (
      .clk        (clk),
      .rst        (rst),
      .lkpIdx_i   (pc[BHT_IDX_W+1:2]),
      .lkpCnt_o   (lkpCnt),
      .updValid_i (upd_valid),
      .updIdx_i   (upd_pc[BHT_IDX_W+1:2]),
      .updTaken_i (upd_taken)
   );

   assign unused_bits = ^{pc[PC_SIZE-1:BHT_IDX_W+2], pc[1:0],
                          upd_pc[PC_SIZE-1:BHT_IDX_W+2], upd_pc[1:0], lkpCnt[0]};

   assign dirTaken   = BHT_EN ? lkpCnt[1] : dec_bjp_imm[XLEN-1];
   assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & dirTaken);

   assign rs1x0 = (dec_jalr_rs1idx == RFIDX_WIDTH'(0));
   assign rs1x1 = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
   assign rs1xn = ~rs1x0 & ~rs1x1;

   assign jalrXnReq = dec_i_valid & dec_jalr & rs1xn;
   assign x1Wait    = dec_i_valid & dec_jalr & rs1x1 & oitf_x1_dep;

   // The RF read request fires only on the transition into RDRF; losing
   // dec_i_valid while waiting abandons the sequence without a read.
   always_comb begin
      state_d = state_q;
      rs1Ena  = 1'b0;
      xnWait  = 1'b0;
      unique case (state_q)
         JALR_IDLE: begin
            if (jalrXnReq) begin
               xnWait = 1'b1;
               if (oitf_rs1_dep && !ir_valid_clr) begin
                  state_d = JALR_DEPW;
               end else begin
                  state_d = JALR_RDRF;
                  rs1Ena  = 1'b1;
               end
            end
         end
         JALR_DEPW: begin
            xnWait = 1'b1;
            if (!dec_i_valid) begin
               state_d = JALR_IDLE;
            end else if (!oitf_rs1_dep || ir_valid_clr) begin
               state_d = JALR_RDRF;
               rs1Ena  = 1'b1;
            end
         end
         JALR_RDRF: begin
            xnWait  = 1'b1;
            state_d = dec_i_valid ? JALR_DONE : JALR_IDLE;
         end
         JALR_DONE: begin
            state_d = JALR_IDLE;
         end
         default: state_d = JALR_IDLE;
      endcase
   end

   assign rs1_d = (state_q == JALR_RDRF) ? rf2bpu_rs1 : rs1_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= JALR_IDLE;
         rs1_q   <= '0;
      end else begin
         state_q <= state_d;
         rs1_q   <= rs1_d;
      end
   end

   // Stall and read request are held low while reset is asserted.
   assign bpu_wait       = rst & (x1Wait | xnWait);
   assign bpu2rf_rs1_ena = rst & rs1Ena;

   always_comb begin
      prdt_pc_add_op1 = pc;
      if (dec_jalr) begin
         if (rs1x0) begin
            prdt_pc_add_op1 = '0;
         end else if (rs1x1) begin
            prdt_pc_add_op1 = rf2bpu_x1[PC_SIZE-1:0];
         end else begin
            prdt_pc_add_op1 = rs1_q[PC_SIZE-1:0];
         end
      end
   end

   assign prdt_pc_add_op2 = dec_bjp_imm[PC_SIZE-1:0];

endmodule

// File: tb/tb_ifu_bhtbpu.sv
// Scoreboard bench for ifu_bhtbpu: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against both predictor modes.
module tb_ifu_bhtbpu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        dec_i_valid, dec_jal, dec_jalr, dec_bxx;
   logic [31:0] dec_bjp_imm;
   logic [4:0]  dec_jalr_rs1idx;
   logic        oitf_x1_dep, oitf_rs1_dep, ir_valid_clr;
   logic [31:0] rf2bpu_x1, rf2bpu_rs1;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;

   logic        bpuWait, prdtTaken, rs1Ena;
   logic [31:0] op1, op2;
   logic        sWait, sTaken, sEna;
   logic [31:0] sOp1, sOp2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic        expWait;
      logic        expTaken;
      logic        expEna;
      logic        expStatic;
      bit          chkOps;
      logic [31:0] expOp1;
      logic [31:0] expOp2;
   } exp_t;

   exp_t sbQueue[$];

   always #5 clk = ~clk;

   ifu_bhtbpu #(.BHT_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_jal(dec_jal),
      .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(dec_bjp_imm),
      .dec_jalr_rs1idx(dec_jalr_rs1idx), .oitf_x1_dep(oitf_x1_dep),
      .oitf_rs1_dep(oitf_rs1_dep), .ir_valid_clr(ir_valid_clr), .rf2bpu_x1(rf2bpu_x1),
      .rf2bpu_rs1(rf2bpu_rs1), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .bpu_wait(bpuWait), .prdt_taken(prdtTaken),
      .prdt_pc_add_op1(op1), .prdt_pc_add_op2(op2), .bpu2rf_rs1_ena(rs1Ena)
   );

   ifu_bhtbpu #(.BHT_EN(1'b0)) dutStatic (
      .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_jal(dec_jal),
      .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(dec_bjp_imm),
      .dec_jalr_rs1idx(dec_jalr_rs1idx), .oitf_x1_dep(oitf_x1_dep),
      .oitf_rs1_dep(oitf_rs1_dep), .ir_valid_clr(ir_valid_clr), .rf2bpu_x1(rf2bpu_x1),
      .rf2bpu_rs1(rf2bpu_rs1), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .bpu_wait(sWait), .prdt_taken(sTaken),
      .prdt_pc_add_op1(sOp1), .prdt_pc_add_op2(sOp2), .bpu2rf_rs1_ena(sEna)
   );

   task automatic cmp(input string nm, input string field, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s.%s actual=%h expected=%h", nm, field, act, exp);
      end
   endtask

   // Monitor: one expectation per sampled cycle, compared away from the edge.
   always @(negedge clk) begin
      if (sbQueue.size() > 0) begin
         exp_t e;
         e = sbQueue.pop_front();
         cmp(e.name, "bpu_wait", 32'(bpuWait), 32'(e.expWait));
         cmp(e.name, "prdt_taken", 32'(prdtTaken), 32'(e.expTaken));
         cmp(e.name, "rs1_ena", 32'(rs1Ena), 32'(e.expEna));
         cmp(e.name, "static_taken", 32'(sTaken), 32'(e.expStatic));
         if (e.chkOps) begin
            cmp(e.name, "op1", op1, e.expOp1);
            cmp(e.name, "op2", op2, e.expOp2);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      dec_i_valid = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
      pc = 32'h0; dec_bjp_imm = 32'h0; dec_jalr_rs1idx = 5'd0;
      oitf_x1_dep = 0; oitf_rs1_dep = 0; ir_valid_clr = 0;
      upd_valid = 0; upd_pc = 32'h0; upd_taken = 0;
   endtask

   task automatic applyStimulus(input logic v, input logic jal, input logic jalr,
                                input logic bxx, input logic [31:0] pcV,
                                input logic [31:0] imm, input logic [4:0] rs1);
      dec_i_valid = v; dec_jal = jal; dec_jalr = jalr; dec_bxx = bxx;
      pc = pcV; dec_bjp_imm = imm; dec_jalr_rs1idx = rs1;
   endtask

   // Static mode direction follows the immediate sign for conditional branches.
   task automatic checkOutput(input string nm, input logic w, input logic t,
                              input logic en, input bit ops, input logic [31:0] o1,
                              input logic [31:0] o2);
      exp_t e;
      e.name = nm; e.expWait = w; e.expTaken = t; e.expEna = en;
      e.expStatic = dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[31]);
      e.chkOps = ops; e.expOp1 = o1; e.expOp2 = o2;
      sbQueue.push_back(e);
   endtask

   task automatic train(input logic [31:0] p, input logic tk, input int n);
      for (int i = 0; i < n; i++) begin
         idleInputs();
         upd_valid = 1; upd_pc = p; upd_taken = tk;
         step();
      end
      idleInputs();
   endtask

   task automatic lookup(input string nm, input logic [31:0] p, input logic t);
      idleInputs();
      applyStimulus(1, 0, 0, 1, p, 32'hFFFF_FFF0, 5'd0);
      checkOutput(nm, 0, t, 0, 1, p, 32'hFFFF_FFF0);
      step();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rf2bpu_x1 = 32'h0; rf2bpu_rs1 = 32'hDEAD_BEEF;
      idleInputs();
      rst = 0;
      step();
      applyStimulus(1, 0, 1, 0, 32'h8000_0000, 32'h4, 5'd5);
      checkOutput("reset", 0, 1, 0, 1, 32'h0, 32'h4);
      step();
      rst = 1;
      idleInputs();
      step();

      lookup("bht_init", 32'h8000_0010, 0);
      train(32'h8000_0010, 1, 2);
      lookup("bht_two_taken", 32'h8000_0010, 1);
      train(32'h8000_0010, 1, 5);
      lookup("bht_sat_hi", 32'h8000_0010, 1);
      train(32'h8000_0010, 0, 1);
      lookup("bht_after_one_nt", 32'h8000_0010, 1);
      train(32'h8000_0010, 0, 2);
      lookup("bht_three_nt", 32'h8000_0010, 0);
      train(32'h8000_0010, 0, 2);
      train(32'h8000_0010, 1, 2);
      lookup("bht_sat_lo", 32'h8000_0010, 1);
      lookup("bht_other_idx", 32'h8000_0014, 0);

      idleInputs();
      applyStimulus(1, 0, 0, 1, 32'h8000_0020, 32'h0000_0040, 5'd0);
      upd_valid = 1; upd_pc = 32'h8000_0020; upd_taken = 1;
      checkOutput("same_cycle_pre", 0, 0, 0, 1, 32'h8000_0020, 32'h40);
      step();
      lookup("same_cycle_post", 32'h8000_0020, 1);
      lookup("alias_idx", 32'h8000_0120, 1);

      idleInputs();
      applyStimulus(1, 0, 0, 0, 32'h8000_0030, 32'h8000_0000, 5'd0);
      checkOutput("non_branch", 0, 0, 0, 0, 32'h0, 32'h0);
      step();

      // JALR x5 with a three-cycle dependency
      idleInputs();
      applyStimulus(1, 0, 1, 0, 32'h8000_0040, 32'h10, 5'd5);
      for (int i = 0; i < 3; i++) begin
         oitf_rs1_dep = 1;
         checkOutput($sformatf("xn_depw%0d", i), 1, 1, 0, 0, 32'h0, 32'h0);
         step();
      end
      oitf_rs1_dep = 0;
      checkOutput("xn_read_req", 1, 1, 1, 0, 32'h0, 32'h0);
      step();
      rf2bpu_rs1 = 32'h8000_1234;
      checkOutput("xn_rdrf", 1, 1, 0, 0, 32'h0, 32'h0);
      step();
      rf2bpu_rs1 = 32'hDEAD_BEEF;
      checkOutput("xn_done", 0, 1, 0, 1, 32'h8000_1234, 32'h10);
      step();

      // JALR x1 waits on its dependency, then JALR x0
      idleInputs();
      applyStimulus(1, 0, 1, 0, 32'h8000_0050, 32'h8, 5'd1);
      rf2bpu_x1 = 32'h8000_0100;
      oitf_x1_dep = 1;
      checkOutput("x1_wait0", 1, 1, 0, 0, 32'h0, 32'h0);
      step();
      checkOutput("x1_wait1", 1, 1, 0, 0, 32'h0, 32'h0);
      step();
      oitf_x1_dep = 0;
      checkOutput("x1_go", 0, 1, 0, 1, 32'h8000_0100, 32'h8);
      step();
      applyStimulus(1, 0, 1, 0, 32'h8000_0054, 32'hC, 5'd0);
      checkOutput("x0_go", 0, 1, 0, 1, 32'h0, 32'hC);
      step();

      // Minimum-latency xn, no dependency
      applyStimulus(1, 0, 1, 0, 32'h8000_0060, 32'h20, 5'd7);
      checkOutput("xn_min_req", 1, 1, 1, 0, 32'h0, 32'h0);
      step();
      rf2bpu_rs1 = 32'h1111_2222;
      checkOutput("xn_min_rdrf", 1, 1, 0, 0, 32'h0, 32'h0);
      step();
      rf2bpu_rs1 = 32'hDEAD_BEEF;
      checkOutput("xn_min_done", 0, 1, 0, 1, 32'h1111_2222, 32'h20);
      step();

      // Abort while waiting, then IR drain forcing the read
      idleInputs();
      applyStimulus(1, 0, 1, 0, 32'h8000_0070, 32'h4, 5'd6);
      oitf_rs1_dep = 1;
      checkOutput("abort_enter", 1, 1, 0, 0, 32'h0, 32'h0);
      step();
      dec_i_valid = 0;
      checkOutput("abort_depw", 1, 1, 0, 0, 32'h0, 32'h0);
      step();
      idleInputs();
      checkOutput("abort_idle", 0, 0, 0, 0, 32'h0, 32'h0);
      step();
      applyStimulus(1, 0, 1, 0, 32'h8000_0070, 32'h4, 5'd6);
      oitf_rs1_dep = 1; ir_valid_clr = 1;
      checkOutput("irclr_req", 1, 1, 1, 0, 32'h0, 32'h0);
      step();
      idleInputs();
      step();
      step();

      // Reset asserted while in RDRF
      applyStimulus(1, 0, 1, 0, 32'h8000_0080, 32'h4, 5'd9);
      checkOutput("rst_seq_req", 1, 1, 1, 0, 32'h0, 32'h0);
      step();
      rst = 0;
      applyStimulus(1, 0, 0, 1, 32'h8000_0020, 32'h40, 5'd0);
      checkOutput("rst_mid", 0, 0, 0, 1, 32'h8000_0020, 32'h40);
      step();
      rst = 1;
      checkOutput("rst_after", 0, 0, 0, 1, 32'h8000_0020, 32'h40);
      step();

      idleInputs();
      step();
      step();
      checks++;
      if (sbQueue.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain actual=%0d pending required=0", sbQueue.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
